pc_unit: RTL
============

# pc_unit

Parametrised program-counter unit for the single-cycle/multi-cycle datapath; successor of the plain 32-bit PC register. Holds the current fetch address and selects the next one from sequential, branch, jump or return sources, with stall support. Includes a small circular return-address stack (RAS) for call/return. It feeds the instruction memory address and the PC+4 path of the datapath.

## Interface
- WIDTH, 32, address width in bits
- RESET_VECTOR, 0, PC value loaded on reset
- INSTR_BYTES, 4, sequential increment; power of two
- RAS_DEPTH, 4, return-address stack entries; power of two, ≥2
- TRAP_VECTOR, 32'h0000_0080, redirect target on misaligned target; used only with PC_ALIGN_CHECK_EN

- clock  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold PC and RAS this cycle
- branch_taken  in  1  redirect to branch_target
- branch_target  in  WIDTH  branch destination
- jump  in  1  redirect to jump_target
- jump_target  in  WIDTH  jump destination; also return fallback
- call  in  1  push pc_plus onto RAS; qualified by jump
- ret  in  1  pop RAS and redirect to popped address
- pc  out  WIDTH  current PC (registered)
- pc_plus  out  WIDTH  pc + INSTR_BYTES (combinational)
- ras_empty  out  1  RAS count == 0
- ras_full  out  1  RAS count == RAS_DEPTH
- ras_underflow  out  1  one-cycle pulse: ret with empty RAS
- misalign  out  1  one-cycle pulse: misaligned target taken (0 without macro)

## Operation
- Next-PC priority: reset > stall > ret > jump > branch_taken > sequential (pc_plus).
- reset: pc <= RESET_VECTOR, RAS count <= 0, pointer <= 0, pulses <= 0. RAS contents not cleared.
- stall: pc, RAS pointer/count unchanged; all other request inputs ignored; pulses <= 0.
- ret, RAS non-empty: pc <= top entry; pointer decrements, count decrements.
- ret, RAS empty: pc <= jump_target; ras_underflow pulses; count stays 0.
- jump: pc <= jump_target. If call also high, pc_plus is pushed.
- call without jump: ignored (no push).
- Push when full: circular overwrite of oldest entry; count stays RAS_DEPTH; no error flag.
- call+jump+ret same cycle: ret wins for pc; RAS top is replaced by pc_plus (pop then push), count unchanged; if empty, pc_plus is pushed, count becomes 1, ras_underflow pulses.
- Arithmetic: pc_plus and pointer wrap modulo 2^WIDTH and RAS_DEPTH respectively; no saturation.

## Timing
- Zero-bubble: redirect selected in cycle N appears on pc after the edge ending cycle N.
- pc_plus valid same cycle as pc; no internal pipeline.
- ras_empty/ras_full reflect registered count; update one edge after push/pop.
- ras_underflow and misalign are high for exactly the cycle following the offending request edge.
- Reset asserted mid-call/ret: reset wins; request discarded.

## Configuration
- PC_ALIGN_CHECK_EN defined: any selected non-sequential target with low log2(INSTR_BYTES) bits ≠ 0 sends pc to TRAP_VECTOR and pulses misalign; a pending push still occurs; a pending pop still occurs.
- Undefined: targets loaded unmodified; misalign tied 0; TRAP_VECTOR unused.

## Test plan
- Reset then 3 free-running cycles -> pc = 0, 4, 8, 12; ras_empty = 1.
- At pc=0x10, branch_taken with branch_target=0x40 and stall=1 -> pc stays 0x10; next cycle stall=0 -> pc = 0x40.
- jump+call at pc=0x20 to 0x100, later ret -> pc = 0x100, then 0x24; ras_empty returns to 1.
- RAS_DEPTH=4: five calls from 0x0,0x10,0x20,0x30,0x40 then five rets -> returns 0x44,0x34,0x24,0x14, then jump_target with ras_underflow pulse.
- jump+ret together with RAS top 0x200 -> pc = 0x200, not jump_target.
- With PC_ALIGN_CHECK_EN, jump to 0x102 -> pc = TRAP_VECTOR, misalign pulses one cycle; without it -> pc = 0x102.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: program-counter unit with a circular return-address stack.
//
// Holds the current fetch address and picks the next one from the
// sequential, branch, jump or return source. Priority:
//   reset > stall > ret > jump > branch_taken > sequential.
// A call is only honoured together with jump, and pushes pc_plus.
// When full, a push overwrites the oldest entry.
//
// Optional feature macro: PC_ALIGN_CHECK_EN. When it is defined, a
// misaligned non-sequential target sends pc to TRAP_VECTOR and pulses
// misalign. When it is undefined, targets load unmodified and misalign is 0.
//
// There is no handshake on this block: every request input is sampled on
// each rising clock edge unless stall is high.

module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               INSTR_BYTES  = 4,
    parameter int               RAS_DEPTH    = 4,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0080)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_underflow,
    output logic             misalign
);

    localparam int               PTR_W      = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(RAS_DEPTH);
    localparam logic [WIDTH-1:0] STEP       = WIDTH'(INSTR_BYTES);

    // Architectural state
    logic [WIDTH-1:0] pc_q;
    logic [PTR_W-1:0] ptr_q;     // next free slot; the top entry sits at ptr_q-1
    logic [PTR_W:0]   count_q;   // valid entries, saturates at RAS_DEPTH
    logic             underflow_q;
    logic             misalign_q;
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

    // Next-state decode
    logic [PTR_W-1:0] top_idx;
    logic [WIDTH-1:0] top_entry;
    logic             ras_nonempty;
    logic [WIDTH-1:0] target;
    logic             redirect;
    logic             do_push;
    logic             do_pop;
    logic             underflow_d;
    logic             misalign_d;
    logic [WIDTH-1:0] pc_d;

    assign pc_plus      = pc_q + STEP;
    assign top_idx      = ptr_q - 1'b1;
    assign top_entry    = ras_mem[top_idx];
    assign ras_nonempty = (count_q != '0);

    // Select the next-PC source and decide which RAS operations happen
    always_comb begin
        target      = pc_plus;
        redirect    = 1'b0;
        do_push     = 1'b0;
        do_pop      = 1'b0;
        underflow_d = 1'b0;
        if (!stall) begin
            if (ret) begin
                redirect = 1'b1;
                if (ras_nonempty) begin
                    target = top_entry;
                    do_pop = 1'b1;
                end else begin
                    target      = jump_target;
                    underflow_d = 1'b1;
                end
            end else if (jump) begin
                redirect = 1'b1;
                target   = jump_target;
            end else if (branch_taken) begin
                redirect = 1'b1;
                target   = branch_target;
            end
            // A call only counts when it rides on a jump.
            do_push = call & jump;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INSTR_BYTES - 1);

    // Trap any redirect whose low address bits are not instruction aligned
    always_comb begin
        misalign_d = redirect && ((target & ALIGN_MASK) != '0);
        pc_d       = misalign_d ? TRAP_VECTOR : target;
    end
`else
    logic unused_trap_vector;
    assign unused_trap_vector = ^TRAP_VECTOR;

    // Targets pass through unmodified; the misalign pulse never fires
    always_comb begin
        misalign_d = 1'b0;
        pc_d       = target;
    end
`endif

    // PC, RAS pointer/count and the one-cycle status pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q        <= RESET_VECTOR;
            ptr_q       <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
            misalign_q  <= misalign_d;
            if (!stall) begin
                pc_q <= pc_d;
            end
            if (do_push && do_pop) begin
                // Pop then push: top replaced, pointer and count unchanged.
                ptr_q   <= ptr_q;
                count_q <= count_q;
            end else if (do_push) begin
                ptr_q <= ptr_q + 1'b1;
                if (count_q != FULL_COUNT) begin
                    count_q <= count_q + 1'b1;
                end
            end else if (do_pop) begin
                ptr_q   <= ptr_q - 1'b1;
                count_q <= count_q - 1'b1;
            end
        end
    end

    // RAS storage; contents deliberately survive reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (do_push && do_pop) begin
                ras_mem[top_idx] <= pc_plus;
            end else if (do_push) begin
                ras_mem[ptr_q] <= pc_plus;
            end
        end
    end

    assign pc            = pc_q;
    assign ras_empty     = (count_q == '0);
    assign ras_full      = (count_q == FULL_COUNT);
    assign ras_underflow = underflow_q;
    assign misalign      = misalign_q;

endmodule
